ndp_layer_sequencer: RTL

//  Schedules multi-layer jobs (e.g. one expert FFN per job) onto a single NDP core. Jobs are queued

---
 rtl/ndp_pkg.sv | 36 +++
 rtl/ndp_job_fifo.sv | 49 ++++
 rtl/ndp_layer_sequencer.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/ndp_pkg.sv
// Shared definitions for the NDP layer sequencer: FSM encoding, core geometry
// and the width of a queued job record.
package ndp_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ARM    = 3'd1,
      ST_STREAM = 3'd2,
      ST_DRAIN  = 3'd3,
      ST_DONE   = 3'd4
   } seq_state_t;

   // Core geometry; one last-layer result is SYS_W*ARR_W*ARR_H*WIDTH bits.
   localparam int CORE_SYS_W = 8;
   localparam int CORE_ARR_W = 4;
   localparam int CORE_ARR_H = 4;
   localparam int CORE_WIDTH = 32;

   function automatic int calc_out_beats(input int sys_w, input int arr_w,
                                         input int arr_h, input int width);
      return (sys_w * arr_w * arr_h * width) / 32;
   endfunction

   localparam int DEF_OUT_BEATS  = calc_out_beats(CORE_SYS_W, CORE_ARR_W, CORE_ARR_H, CORE_WIDTH);
   localparam int DEF_MAX_LAYERS = 8;
   localparam int DEF_LAYER_W    = 4;
   localparam int DEF_ID_W       = 4;
   localparam int DEF_JOB_DEPTH  = 4;
   localparam int DEF_BEAT_W     = 16;

   // Job record layout (MSB first): {id, layers, relu_mask}.
   function automatic int job_rec_w(input int id_w, input int layer_w, input int max_layers);
      return id_w + layer_w + max_layers;
   endfunction

endpackage

// File: rtl/ndp_job_fifo.sv
// Small synchronous job queue with first-word-fall-through read; a push while
// full is dropped regardless of a simultaneous pop.
module ndp_job_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr_reg;
   logic [AW:0]      rd_ptr_reg;
   logic             do_push;
   logic             do_pop;

   // Extra pointer bit distinguishes full from empty when the indices match.
   assign full     = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
   assign empty    = (wr_ptr_reg == rd_ptr_reg);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_data = mem[rd_ptr_reg[AW-1:0]];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr_reg[AW-1:0]] <= push_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
   end

endmodule

// File: rtl/ndp_layer_sequencer.sv
// Queues multi-layer jobs and steps a single NDP core through them, one read
// trigger toggle per layer, tracking progress from the core's stream handshakes.
module ndp_layer_sequencer
   import ndp_pkg::*;
#(
   parameter int MAX_LAYERS = DEF_MAX_LAYERS,
   parameter int LAYER_W    = DEF_LAYER_W,
   parameter int ID_W       = DEF_ID_W,
   parameter int JOB_DEPTH  = DEF_JOB_DEPTH,
   parameter int OUT_BEATS  = DEF_OUT_BEATS,
   parameter int BEAT_W     = DEF_BEAT_W
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  job_valid,
   output logic                  job_ready,
   input  logic [ID_W-1:0]       job_id,
   input  logic [LAYER_W-1:0]    job_layers,
   input  logic [MAX_LAYERS-1:0] job_relu_mask,
   output logic                  ndp_is_relu,
   output logic                  ndp_is_last,
   output logic                  ndp_read_trigger,
   input  logic                  mon_s_tvalid,
   input  logic                  mon_s_tready,
   input  logic                  mon_s_tlast,
   input  logic                  mon_m_tvalid,
   input  logic                  mon_m_tready,
   input  logic                  mon_m_tlast,
   output logic                  done_valid,
   output logic [ID_W-1:0]       done_id,
   output logic [BEAT_W-1:0]     done_beats,
   output logic                  done_err,
   output logic                  busy
);

   localparam int REC_W = job_rec_w(ID_W, LAYER_W, MAX_LAYERS);
   localparam int OBW   = BEAT_W + 1;
   localparam logic [LAYER_W-1:0] MAX_L          = LAYER_W'(MAX_LAYERS);
   localparam logic [OBW-1:0]     OUT_BEATS_C    = OBW'(OUT_BEATS);

   seq_state_t state_reg, state_next;

   logic [REC_W-1:0]      push_rec;
   logic [REC_W-1:0]      pop_rec;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic                  fifo_pop;
   logic [ID_W-1:0]       pop_id;
   logic [LAYER_W-1:0]    pop_layers;
   logic [MAX_LAYERS-1:0] pop_mask;
   logic                  layers_ok;

   logic                  s_acc, s_last, m_acc, m_last;

   logic [ID_W-1:0]       id_reg, id_next;
   logic [LAYER_W-1:0]    layers_reg, layers_next;
   logic [MAX_LAYERS-1:0] mask_reg, mask_next;
   logic [LAYER_W-1:0]    layer_idx_reg, layer_idx_next;
   logic [BEAT_W-1:0]     beats_reg, beats_next;
   logic [BEAT_W-1:0]     out_cnt_reg, out_cnt_next;
   logic                  err_reg, err_next;
   logic                  is_relu_reg, is_relu_next;
   logic                  is_last_reg, is_last_next;
   logic                  trigger_reg, trigger_next;
   logic                  done_valid_reg, done_valid_next;
   logic [ID_W-1:0]       done_id_reg, done_id_next;
   logic [BEAT_W-1:0]     done_beats_reg, done_beats_next;
   logic                  done_err_reg, done_err_next;

   logic [MAX_LAYERS-1:0] mask_shift;
   logic [OBW-1:0]        out_cnt_plus;
   logic                  err_acc;
   logic                  err_fin;

   assign push_rec   = {job_id, job_layers, job_relu_mask};
   assign pop_id     = pop_rec[REC_W-1 -: ID_W];
   assign pop_layers = pop_rec[MAX_LAYERS +: LAYER_W];
   assign pop_mask   = pop_rec[MAX_LAYERS-1:0];
   assign layers_ok  = (pop_layers != '0) && (pop_layers <= MAX_L);
   assign fifo_pop   = (state_reg == ST_IDLE) && !fifo_empty;
   assign job_ready  = !fifo_full;

   assign s_acc  = mon_s_tvalid && mon_s_tready;
   assign s_last = s_acc && mon_s_tlast;
   assign m_acc  = mon_m_tvalid && mon_m_tready;
   assign m_last = m_acc && mon_m_tlast;

   ndp_job_fifo #(
      .DEPTH (JOB_DEPTH),
      .WIDTH (REC_W)
   ) u_job_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (job_valid),
      .push_data (push_rec),
      .pop       (fifo_pop),
      .pop_data  (pop_rec),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg      <= ST_IDLE;
         id_reg         <= '0;
         layers_reg     <= '0;
         mask_reg       <= '0;
         layer_idx_reg  <= '0;
         beats_reg      <= '0;
         out_cnt_reg    <= '0;
         err_reg        <= 1'b0;
         is_relu_reg    <= 1'b0;
         is_last_reg    <= 1'b0;
         trigger_reg    <= 1'b0;
         done_valid_reg <= 1'b0;
         done_id_reg    <= '0;
         done_beats_reg <= '0;
         done_err_reg   <= 1'b0;
      end else begin
         state_reg      <= state_next;
         id_reg         <= id_next;
         layers_reg     <= layers_next;
         mask_reg       <= mask_next;
         layer_idx_reg  <= layer_idx_next;
         beats_reg      <= beats_next;
         out_cnt_reg    <= out_cnt_next;
         err_reg        <= err_next;
         is_relu_reg    <= is_relu_next;
         is_last_reg    <= is_last_next;
         trigger_reg    <= trigger_next;
         done_valid_reg <= done_valid_next;
         done_id_reg    <= done_id_next;
         done_beats_reg <= done_beats_next;
         done_err_reg   <= done_err_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE:   if (!fifo_empty) state_next = layers_ok ? ST_ARM : ST_DONE;
         ST_ARM:    state_next = ST_STREAM;
         ST_STREAM: if (s_last) state_next = is_last_reg ? ST_DRAIN : ST_ARM;
         ST_DRAIN:  if (m_last) state_next = ST_DONE;
         ST_DONE:   state_next = ST_IDLE;
         default:   state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      id_next         = id_reg;
      layers_next     = layers_reg;
      mask_next       = mask_reg;
      layer_idx_next  = layer_idx_reg;
      beats_next      = beats_reg;
      out_cnt_next    = out_cnt_reg;
      is_relu_next    = is_relu_reg;
      is_last_next    = is_last_reg;
      trigger_next    = trigger_reg;
      done_valid_next = 1'b0;
      done_id_next    = done_id_reg;
      done_beats_next = done_beats_reg;
      done_err_next   = done_err_reg;
      mask_shift      = mask_reg >> layer_idx_reg;
      out_cnt_plus    = {1'b0, out_cnt_reg} + OBW'(1);
      // Result beats outside DRAIN mean the core and sequencer disagree.
      err_acc         = err_reg || (m_acc && (state_reg != ST_DRAIN));
      err_fin         = err_acc || (out_cnt_plus != OUT_BEATS_C);
      err_next        = err_acc;

      case (state_reg)
         ST_IDLE: begin
            if (!fifo_empty) begin
               id_next        = pop_id;
               layers_next    = pop_layers;
               mask_next      = pop_mask;
               layer_idx_next = '0;
               beats_next     = '0;
               out_cnt_next   = '0;
               err_next       = !layers_ok;
               if (!layers_ok) begin
                  done_valid_next = 1'b1;
                  done_id_next    = pop_id;
                  done_beats_next = '0;
                  done_err_next   = 1'b1;
               end
            end
         end
         ST_ARM: begin
            is_relu_next = mask_shift[0];
            is_last_next = (layer_idx_reg == (layers_reg - LAYER_W'(1)));
            trigger_next = !trigger_reg;
         end
         ST_STREAM: begin
            if (s_acc && (beats_reg != '1)) beats_next = beats_reg + 1'b1;
            if (s_last && !is_last_reg) layer_idx_next = layer_idx_reg + 1'b1;
         end
         ST_DRAIN: begin
            if (m_acc && (out_cnt_reg != '1)) out_cnt_next = out_cnt_reg + 1'b1;
            if (m_last) begin
               err_next        = err_fin;
               done_valid_next = 1'b1;
               done_id_next    = id_reg;
               done_beats_next = beats_reg;
               done_err_next   = err_fin;
            end
         end
         default: begin
         end
      endcase
   end

   assign ndp_is_relu      = is_relu_reg;
   assign ndp_is_last      = is_last_reg;
   assign ndp_read_trigger = trigger_reg;
   assign done_valid       = done_valid_reg;
   assign done_id          = done_id_reg;
   assign done_beats       = done_beats_reg;
   assign done_err         = done_err_reg;
   assign busy             = (state_reg != ST_IDLE);

endmodule
